// File: rtl/csr_file.sv
// csr_file: privileged CSR block with exception entry/return and interrupt status.
// Define CSR_TIMER_EN to build TID/TCFG/TVAL/TICLR and the timer interrupt IS[11].
module csr_file #(
    parameter logic [31:0] TID_RST = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] csr_rnum,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [13:0] csr_wnum,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wval,
    input  logic        wb_exc,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_badvaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_pc,
    output logic        has_int
);

    localparam logic [13:0] CSR_CRMD   = 14'h0000;
    localparam logic [13:0] CSR_PRMD   = 14'h0001;
    localparam logic [13:0] CSR_ECFG   = 14'h0004;
    localparam logic [13:0] CSR_ESTAT  = 14'h0005;
    localparam logic [13:0] CSR_ERA    = 14'h0006;
    localparam logic [13:0] CSR_BADV   = 14'h0007;
    localparam logic [13:0] CSR_EENTRY = 14'h000C;
    localparam logic [13:0] CSR_SAVE0  = 14'h0030;
    localparam logic [13:0] CSR_SAVE1  = 14'h0031;
    localparam logic [13:0] CSR_SAVE2  = 14'h0032;
    localparam logic [13:0] CSR_SAVE3  = 14'h0033;
    localparam logic [13:0] CSR_TID    = 14'h0040;
    localparam logic [13:0] CSR_TCFG   = 14'h0041;
    localparam logic [13:0] CSR_TVAL   = 14'h0042;
    localparam logic [13:0] CSR_TICLR  = 14'h0044;

    // LIE bit 10 has no interrupt source behind it
    localparam logic [12:0] LIE_MASK = 13'h1BFF;

    logic [3:0]  crmd_r;
    logic [2:0]  prmd_r;
    logic [12:0] ecfg_lie_r;
    logic [1:0]  is_soft_r;
    logic [7:0]  is_hw_r;
    logic        is_ipi_r;
    logic        is_timer_s;
    logic [5:0]  estat_ecode_r;
    logic [8:0]  estat_esub_r;
    logic [31:0] era_r;
    logic [31:0] badv_r;
    logic [25:0] eentry_r;
    logic [31:0] save0_r;
    logic [31:0] save1_r;
    logic [31:0] save2_r;
    logic [31:0] save3_r;
    logic [12:0] estat_is_s;
    logic [31:0] wr_merge_s;

`ifdef CSR_TIMER_EN
    logic [31:0] tid_r;
    logic [31:0] tcfg_r;
    logic [31:0] tval_r;
    logic        timer_armed_r;
    logic        is_timer_r;
    logic        timer_fire_s;
    logic        ticlr_clr_s;
`endif

    function automatic logic [31:0] mask_merge(input logic [31:0] old_v,
                                               input logic [31:0] val_v,
                                               input logic [31:0] mask_v);
        return (val_v & mask_v) | (old_v & ~mask_v);
    endfunction

    // Architectural view of a CSR; unimplemented bits and numbers read as zero
    function automatic logic [31:0] csr_image(input logic [13:0] num);
        logic [31:0] v;
        v = 32'h0;
        case (num)
            CSR_CRMD:   v = {28'h0, crmd_r};
            CSR_PRMD:   v = {29'h0, prmd_r};
            CSR_ECFG:   v = {19'h0, ecfg_lie_r};
            CSR_ESTAT:  v = {1'b0, estat_esub_r, estat_ecode_r, 3'b000, estat_is_s};
            CSR_ERA:    v = era_r;
            CSR_BADV:   v = badv_r;
            CSR_EENTRY: v = {eentry_r, 6'h00};
            CSR_SAVE0:  v = save0_r;
            CSR_SAVE1:  v = save1_r;
            CSR_SAVE2:  v = save2_r;
            CSR_SAVE3:  v = save3_r;
`ifdef CSR_TIMER_EN
            CSR_TID:    v = tid_r;
            CSR_TCFG:   v = tcfg_r;
            CSR_TVAL:   v = tval_r;
`endif
            default:    v = 32'h0;
        endcase
        return v;
    endfunction

    assign estat_is_s = {is_ipi_r, is_timer_s, 1'b0, is_hw_r, is_soft_r};
    assign csr_rvalue = csr_image(csr_rnum);
    // Merge against the write target's current image so every register takes its own field slice
    assign wr_merge_s = mask_merge(csr_image(csr_wnum), csr_wval, csr_wmask);

    assign ex_entry = {eentry_r, 6'h00};
    assign ertn_pc  = era_r;
    assign has_int  = crmd_r[2] & (|(estat_is_s & ecfg_lie_r));

    // CRMD: exception entry beats ERTN beats software write on PLV/IE; DA is software only
    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_r <= 4'h8;
        end else begin
            if (wb_exc) begin
                crmd_r[2:0] <= 3'b000;
            end else if (ertn_flush) begin
                crmd_r[2:0] <= prmd_r;
            end else if (csr_we && (csr_wnum == CSR_CRMD)) begin
                crmd_r[2:0] <= wr_merge_s[2:0];
            end else begin
                crmd_r[2:0] <= crmd_r[2:0];
            end
            if (csr_we && (csr_wnum == CSR_CRMD)) begin
                crmd_r[3] <= wr_merge_s[3];
            end else begin
                crmd_r[3] <= crmd_r[3];
            end
        end
    end

    // PRMD and ERA capture the interrupted context on exception entry
    always_ff @(posedge clk) begin
        if (reset) begin
            prmd_r <= 3'b000;
            era_r  <= 32'h0;
        end else begin
            if (wb_exc) begin
                prmd_r <= crmd_r[2:0];
            end else if (csr_we && (csr_wnum == CSR_PRMD)) begin
                prmd_r <= wr_merge_s[2:0];
            end else begin
                prmd_r <= prmd_r;
            end
            if (wb_exc) begin
                era_r <= wb_pc;
            end else if (csr_we && (csr_wnum == CSR_ERA)) begin
                era_r <= wr_merge_s;
            end else begin
                era_r <= era_r;
            end
        end
    end

    // BADV follows the faulting PC for fetch-address faults and the data address for ecode 9
    always_ff @(posedge clk) begin
        if (reset) begin
            badv_r <= 32'h0;
        end else if (wb_exc && (wb_ecode == 6'h08) && (wb_esubcode == 9'h000)) begin
            badv_r <= wb_pc;
        end else if (wb_exc && (wb_ecode == 6'h09)) begin
            badv_r <= wb_badvaddr;
        end else if (csr_we && (csr_wnum == CSR_BADV)) begin
            badv_r <= wr_merge_s;
        end else begin
            badv_r <= badv_r;
        end
    end

    // ESTAT: cause fields from exceptions, level interrupts resampled every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            is_soft_r     <= 2'b00;
            is_hw_r       <= 8'h00;
            is_ipi_r      <= 1'b0;
            estat_ecode_r <= 6'h00;
            estat_esub_r  <= 9'h000;
        end else begin
            is_hw_r  <= hw_int_in;
            is_ipi_r <= ipi_int_in;
            if (csr_we && (csr_wnum == CSR_ESTAT)) begin
                is_soft_r <= wr_merge_s[1:0];
            end else begin
                is_soft_r <= is_soft_r;
            end
            if (wb_exc) begin
                estat_ecode_r <= wb_ecode;
                estat_esub_r  <= wb_esubcode;
            end else begin
                estat_ecode_r <= estat_ecode_r;
                estat_esub_r  <= estat_esub_r;
            end
        end
    end

    // Plain software-owned registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ecfg_lie_r <= 13'h0000;
            eentry_r   <= 26'h0;
            save0_r    <= 32'h0;
            save1_r    <= 32'h0;
            save2_r    <= 32'h0;
            save3_r    <= 32'h0;
        end else if (csr_we) begin
            case (csr_wnum)
                CSR_ECFG:   ecfg_lie_r <= wr_merge_s[12:0] & LIE_MASK;
                CSR_EENTRY: eentry_r   <= wr_merge_s[31:6];
                CSR_SAVE0:  save0_r    <= wr_merge_s;
                CSR_SAVE1:  save1_r    <= wr_merge_s;
                CSR_SAVE2:  save2_r    <= wr_merge_s;
                CSR_SAVE3:  save3_r    <= wr_merge_s;
                default:    ecfg_lie_r <= ecfg_lie_r;
            endcase
        end else begin
            ecfg_lie_r <= ecfg_lie_r;
        end
    end

`ifdef CSR_TIMER_EN
    // A TCFG write reloads and rearms, so it suppresses a same-cycle expiry
    assign timer_fire_s = tcfg_r[0] && timer_armed_r && (tval_r == 32'h0) &&
                          !(csr_we && (csr_wnum == CSR_TCFG));
    assign ticlr_clr_s  = csr_we && (csr_wnum == CSR_TICLR) && wr_merge_s[0];
    assign is_timer_s   = is_timer_r;

    // Countdown timer: reload on TCFG write, periodic reload or one-shot park at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            tid_r         <= TID_RST;
            tcfg_r        <= 32'h0;
            tval_r        <= 32'h0;
            timer_armed_r <= 1'b0;
        end else begin
            if (csr_we && (csr_wnum == CSR_TID)) begin
                tid_r <= wr_merge_s;
            end else begin
                tid_r <= tid_r;
            end
            if (csr_we && (csr_wnum == CSR_TCFG)) begin
                tcfg_r        <= wr_merge_s;
                tval_r        <= {wr_merge_s[31:2], 2'b00};
                timer_armed_r <= wr_merge_s[0];
            end else if (tcfg_r[0] && timer_armed_r) begin
                if (tval_r != 32'h0) begin
                    tval_r <= tval_r - 32'h1;
                end else if (tcfg_r[1]) begin
                    tval_r <= {tcfg_r[31:2], 2'b00};
                end else begin
                    tval_r        <= 32'hFFFF_FFFF;
                    timer_armed_r <= 1'b0;
                end
            end else begin
                tval_r <= tval_r;
            end
        end
    end

    // Timer interrupt flag: expiry wins over a coincident TICLR clear
    always_ff @(posedge clk) begin
        if (reset) begin
            is_timer_r <= 1'b0;
        end else if (timer_fire_s) begin
            is_timer_r <= 1'b1;
        end else if (ticlr_clr_s) begin
            is_timer_r <= 1'b0;
        end else begin
            is_timer_r <= is_timer_r;
        end
    end
`else
    logic unused_tid_rst_s;
    assign is_timer_s       = 1'b0;
    assign unused_tid_rst_s = ^TID_RST;
`endif

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: register table, exception/ERTN sequences, interrupts, timer.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] csr_rnum;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [13:0] csr_wnum;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wval;
    logic        wb_exc;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_badvaddr;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] ex_entry;
    logic [31:0] ertn_pc;
    logic        has_int;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [13:0] num;
        logic [31:0] wval;
        logic [31:0] wmask;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    csr_file #(.TID_RST(32'h0000_00A5)) dut (
        .clk(clk), .reset(reset),
        .csr_rnum(csr_rnum), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wnum(csr_wnum), .csr_wmask(csr_wmask), .csr_wval(csr_wval),
        .wb_exc(wb_exc), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_badvaddr(wb_badvaddr),
        .ertn_flush(ertn_flush), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .ex_entry(ex_entry), .ertn_pc(ertn_pc), .has_int(has_int)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [13:0] num, input logic [31:0] val, input logic [31:0] mask);
        csr_we = 1'b1; csr_wnum = num; csr_wval = val; csr_wmask = mask;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic csr_read(input logic [13:0] num, output logic [31:0] val);
        csr_rnum = num;
        #1;
        val = csr_rvalue;
    endtask

    task automatic check_csr(input string name, input logic [13:0] num, input logic [31:0] exp);
        logic [31:0] v;
        csr_read(num, v);
        check(name, v, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        int n;
        reset = 1'b1; csr_rnum = 14'h0; csr_we = 1'b0; csr_wnum = 14'h0;
        csr_wmask = 32'h0; csr_wval = 32'h0; wb_exc = 1'b0; wb_ecode = 6'h0;
        wb_esubcode = 9'h0; wb_pc = 32'h0; wb_badvaddr = 32'h0; ertn_flush = 1'b0;
        hw_int_in = 8'h0; ipi_int_in = 1'b0;

        vecs[0]  = '{14'h0000, 32'h0000_000F, 32'h0000_0004, 32'h0000_000C};
        vecs[1]  = '{14'h0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0007};
        vecs[2]  = '{14'h0004, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1BFF};
        vecs[3]  = '{14'h0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0003};
        vecs[4]  = '{14'h0006, 32'h1234_5678, 32'hFFFF_0000, 32'h1234_0000};
        vecs[5]  = '{14'h0007, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'hA5A5_A5A5};
        vecs[6]  = '{14'h000C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFC0};
        vecs[7]  = '{14'h0030, 32'h1111_1111, 32'hFFFF_FFFF, 32'h1111_1111};
        vecs[8]  = '{14'h0033, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'h0000_BEEF};
        vecs[9]  = '{14'h0099, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[10] = '{14'h0006, 32'h0000_0000, 32'h0000_FFFF, 32'h1234_0000};
        vecs[11] = '{14'h0044, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000};

        tick(); tick();
        reset = 1'b0;

        // reset state
        check_csr("rst_crmd", 14'h0000, 32'h8);
        check_csr("rst_prmd", 14'h0001, 32'h0);
        check_csr("rst_ecfg", 14'h0004, 32'h0);
        check_csr("rst_estat", 14'h0005, 32'h0);
        check_csr("rst_era", 14'h0006, 32'h0);
        check_csr("rst_eentry", 14'h000C, 32'h0);
`ifdef CSR_TIMER_EN
        check_csr("rst_tid", 14'h0040, 32'h0000_00A5);
`else
        check_csr("rst_tid", 14'h0040, 32'h0);
`endif
        check("rst_has_int", {31'd0, has_int}, 32'h0);
        check("rst_ex_entry", ex_entry, 32'h0);
        check("rst_ertn_pc", ertn_pc, 32'h0);

        // masked write / readback table
        for (int i = 0; i < 12; i++) begin
            csr_write(vecs[i].num, vecs[i].wval, vecs[i].wmask);
            csr_read(vecs[i].num, v);
            check($sformatf("vec%0d_csr%02h", i, vecs[i].num), v, vecs[i].exp);
        end
        check("tbl_ex_entry", ex_entry, 32'hFFFF_FFC0);
        check("tbl_ertn_pc", ertn_pc, 32'h1234_0000);
        check("tbl_soft_has_int", {31'd0, has_int}, 32'h1);

        // exception entry with ecode 9 then ERTN
        do_reset();
        csr_write(14'h0000, 32'h7, 32'h7);
        check_csr("crmd_pre_exc", 14'h0000, 32'hF);
        wb_exc = 1'b1; wb_ecode = 6'h09; wb_esubcode = 9'h0;
        wb_pc = 32'h1c00_0100; wb_badvaddr = 32'h0000_1001;
        tick();
        wb_exc = 1'b0;
        check_csr("exc9_crmd", 14'h0000, 32'h8);
        check_csr("exc9_prmd", 14'h0001, 32'h7);
        check_csr("exc9_era", 14'h0006, 32'h1c00_0100);
        check_csr("exc9_badv", 14'h0007, 32'h0000_1001);
        check_csr("exc9_estat", 14'h0005, 32'h0009_0000);
        check("exc9_ertn_pc", ertn_pc, 32'h1c00_0100);
        ertn_flush = 1'b1;
        tick();
        ertn_flush = 1'b0;
        check_csr("ertn_crmd", 14'h0000, 32'hF);

        // ecode 8 exception beats a same-cycle ERA write
        wb_exc = 1'b1; wb_ecode = 6'h08; wb_esubcode = 9'h0; wb_pc = 32'h1c00_0200;
        csr_write(14'h0006, 32'h0000_DEAD, 32'hFFFF_FFFF);
        wb_exc = 1'b0;
        check_csr("exc8_era", 14'h0006, 32'h1c00_0200);
        check_csr("exc8_badv", 14'h0007, 32'h1c00_0200);
        check_csr("exc8_estat", 14'h0005, 32'h0008_0000);

        // ERTN beats CRMD write on PLV/IE, DA still takes the write
        ertn_flush = 1'b1;
        csr_write(14'h0000, 32'h0, 32'hF);
        ertn_flush = 1'b0;
        check_csr("ertn_we_crmd", 14'h0000, 32'h7);

        // other ecode leaves BADV alone, subcode captured
        wb_exc = 1'b1; wb_ecode = 6'h01; wb_esubcode = 9'h1FF; wb_pc = 32'h1c00_0300;
        wb_badvaddr = 32'h0BAD_0BAD;
        tick();
        wb_exc = 1'b0;
        check_csr("exc1_badv", 14'h0007, 32'h1c00_0200);
        check_csr("exc1_estat", 14'h0005, 32'h7FC1_0000);
        check_csr("exc1_crmd", 14'h0000, 32'h0);
        check_csr("exc1_prmd", 14'h0001, 32'h7);

        // hardware interrupt latency and reset override
        do_reset();
        csr_write(14'h0004, 32'h0000_0004, 32'hFFFF_FFFF);
        csr_write(14'h0000, 32'h4, 32'h4);
        hw_int_in = 8'h01;
        check("hw_before_edge", {31'd0, has_int}, 32'h0);
        tick();
        check("hw_has_int", {31'd0, has_int}, 32'h1);
        check_csr("hw_estat", 14'h0005, 32'h0000_0004);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_csr("hw_rst_estat", 14'h0005, 32'h0);
        check("hw_rst_has_int", {31'd0, has_int}, 32'h0);
        hw_int_in = 8'h00;

`ifdef CSR_TIMER_EN
        // periodic timer: 16 down to 0, reload, TICLR
        do_reset();
        csr_write(14'h0041, 32'h13, 32'hFFFF_FFFF);
        for (int k = 16; k >= 0; k--) begin
            check_csr($sformatf("tval_%0d", k), 14'h0042, k);
            if (k > 0) tick();
        end
        tick();
        check_csr("tval_reload", 14'h0042, 32'd16);
        check_csr("tmr_is11_set", 14'h0005, 32'h0000_0800);
        csr_write(14'h0044, 32'h1, 32'h1);
        check_csr("ticlr_clear", 14'h0005, 32'h0);
        n = 0;
        csr_read(14'h0042, v);
        while (v != 32'h0 && n < 40) begin
            tick(); n++;
            csr_read(14'h0042, v);
        end
        check("tval_reach_zero", v, 32'h0);
        csr_write(14'h0044, 32'h1, 32'h1);
        check_csr("ticlr_vs_expiry", 14'h0005, 32'h0000_0800);

        // one-shot timer raises has_int then parks
        do_reset();
        csr_write(14'h0004, 32'h800, 32'hFFFF_FFFF);
        csr_write(14'h0000, 32'h4, 32'h4);
        csr_write(14'h0041, 32'h9, 32'hFFFF_FFFF);
        check_csr("os_tval_init", 14'h0042, 32'd8);
        n = 0;
        csr_read(14'h0042, v);
        while (v != 32'h0 && n < 40) begin
            tick(); n++;
            csr_read(14'h0042, v);
        end
        check("os_reach_zero", v, 32'h0);
        check("os_no_int_yet", {31'd0, has_int}, 32'h0);
        tick();
        check("os_has_int", {31'd0, has_int}, 32'h1);
        check_csr("os_tval_park", 14'h0042, 32'hFFFF_FFFF);
        csr_write(14'h0044, 32'h1, 32'h1);
        check("os_int_cleared", {31'd0, has_int}, 32'h0);
        repeat (20) tick();
        check_csr("os_no_reset", 14'h0005, 32'h0);
        check_csr("os_tval_hold", 14'h0042, 32'hFFFF_FFFF);
`else
        // timer absent: its CSRs ignore writes and IS[11] never sets
        do_reset();
        csr_write(14'h0041, 32'h13, 32'hFFFF_FFFF);
        csr_write(14'h0040, 32'h1234_5678, 32'hFFFF_FFFF);
        repeat (20) tick();
        check_csr("nt_tcfg", 14'h0041, 32'h0);
        check_csr("nt_tid", 14'h0040, 32'h0);
        check_csr("nt_tval", 14'h0042, 32'h0);
        check_csr("nt_estat", 14'h0005, 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
